// File: rtl/j1_irq_pkg.sv
// Shared constants for the j1 interrupt controller: register offsets, the
// "nothing pending" CLAIM code and the default source count.
package j1_irq_pkg;

  localparam int NSRC_DEFAULT = 8;

  localparam logic [1:0] OFF_PENDING = 2'd0;
  localparam logic [1:0] OFF_ENABLE  = 2'd1;
  localparam logic [1:0] OFF_CLAIM   = 2'd2;
  localparam logic [1:0] OFF_MODE    = 2'd3;

  localparam logic [31:0] CLAIM_NONE = 32'h8000_0000;

endpackage

// File: rtl/j1_irq_src.sv
// Per-source front end: sample (or 2-flop sync with J1_IRQ_SYNC_EN), edge detect, edge/level select.
// Latency: set follows src by 1 edge (2 with J1_IRQ_SYNC_EN); no backpressure, set is a pure pulse/level.
module j1_irq_src (
  input  logic clk,
  input  logic resetq,
  input  logic src,
  input  logic mode,
  output logic set
);

  logic s;
  logic p;

`ifdef J1_IRQ_SYNC_EN
  logic meta;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= src;
      s    <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) s <= 1'b0;
    else         s <= src;
  end
`endif

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) p <= 1'b0;
    else         p <= s;
  end

  assign set = mode ? (s & ~p) : s;

endmodule

// File: rtl/j1_irq_ctrl.sv
// Interrupt controller for the j1 IO bus: pending/enable/claim/mode registers, request to the core.
// Latency: src high to interrupt_request in 3 edges (4 with J1_IRQ_SYNC_EN); reads combinational.
// Backpressure: none; IO strobes always accepted in one cycle, set wins over clear.
module j1_irq_ctrl
  import j1_irq_pkg::*;
#(
  parameter int NSRC    = NSRC_DEFAULT,
  parameter int SEL_BIT = 13
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [31:0]     io_addr,
  input  logic [31:0]     io_dout,
  input  logic [NSRC-1:0] src,
  output logic            irq_sel,
  output logic [31:0]     irq_din,
  output logic            interrupt_request
);

  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] set;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] claim_onehot;
  logic [4:0]      claim_idx;
  logic            claim_vld;
  logic [1:0]      off;
  logic            unused_bits;

  assign unused_bits = ^{io_addr, io_dout};

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    j1_irq_src u_src (
      .clk    (clk),
      .resetq (resetq),
      .src    (src[i]),
      .mode   (mode[i]),
      .set    (set[i])
    );
  end

  assign irq_sel = io_addr[SEL_BIT];
  assign off     = io_addr[3:2];
  assign active  = pending & enable;

  // Descending scan so the lowest-numbered active source ends up in claim_idx.
  always_comb begin
    claim_idx = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) claim_idx = 5'(i);
    end
  end

  assign claim_vld    = |active;
  assign claim_onehot = claim_vld ? (NSRC'(1) << claim_idx) : '0;

  always_comb begin
    clr = '0;
    if (io_wr && irq_sel && off == OFF_PENDING) clr = clr | io_dout[NSRC-1:0];
    if (io_rd && irq_sel && off == OFF_CLAIM)   clr = clr | claim_onehot;
  end

  always_comb begin
    irq_din = '0;
    if (irq_sel) begin
      case (off)
        OFF_PENDING: irq_din[NSRC-1:0] = pending;
        OFF_ENABLE:  irq_din[NSRC-1:0] = enable;
        OFF_CLAIM:   irq_din = claim_vld ? {27'd0, claim_idx} : CLAIM_NONE;
        default:     irq_din[NSRC-1:0] = mode;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pending           <= '0;
      enable            <= '0;
      mode              <= '1;
      interrupt_request <= 1'b0;
    end else begin
      pending           <= set | (pending & ~clr);
      interrupt_request <= |active;
      if (io_wr && irq_sel && off == OFF_ENABLE) enable <= io_dout[NSRC-1:0];
      if (io_wr && irq_sel && off == OFF_MODE)   mode   <= io_dout[NSRC-1:0];
    end
  end

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// Randomised plus directed bench for j1_irq_ctrl against a delay-line behavioural model.
module tb_j1_irq_ctrl;

  localparam int D   = `ifdef J1_IRQ_SYNC_EN 2 `else 1 `endif ;
  localparam int LAT = D + 2;
  localparam logic [31:0] NONE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_dout = '0;
  logic [7:0]  src = '0;
  logic        irq_sel;
  logic [31:0] irq_din;
  logic        interrupt_request;

  int checks = 0;
  int errors = 0;

  j1_irq_ctrl #(.NSRC(8), .SEL_BIT(13)) dut (
    .clk               (clk),
    .resetq            (resetq),
    .io_rd             (io_rd),
    .io_wr             (io_wr),
    .io_addr           (io_addr),
    .io_dout           (io_dout),
    .src               (src),
    .irq_sel           (irq_sel),
    .irq_din           (irq_din),
    .interrupt_request (interrupt_request)
  );

  initial forever #5 clk = ~clk;

  // Model state: sh0 is the newest src sample, older samples follow.
  logic [7:0] m_pend = '0, m_en = '0, m_mode = 8'hFF;
  logic [7:0] sh0 = '0, sh1 = '0, sh2 = '0;
  logic       m_req = 1'b0;

  function automatic logic [31:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return NONE;
  endfunction

  always @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      m_pend <= '0; m_en <= '0; m_mode <= 8'hFF; m_req <= 1'b0;
      sh0 <= '0; sh1 <= '0; sh2 <= '0;
    end else begin
      logic       sel;
      logic [1:0] off;
      logic [7:0] s, p, setv, clrv;
      logic [31:0] c;
      sel  = io_addr[13];
      off  = io_addr[3:2];
      s    = (D == 1) ? sh0 : sh1;
      p    = (D == 1) ? sh1 : sh2;
      setv = (m_mode & s & ~p) | (~m_mode & s);
      clrv = '0;
      if (io_wr && sel && off == 2'd0) clrv = io_dout[7:0];
      c = lowest(m_pend & m_en);
      if (io_rd && sel && off == 2'd2 && c != NONE) clrv = clrv | (8'd1 << c[2:0]);
      m_req  <= |(m_pend & m_en);
      m_pend <= setv | (m_pend & ~clrv);
      if (io_wr && sel && off == 2'd1) m_en   <= io_dout[7:0];
      if (io_wr && sel && off == 2'd3) m_mode <= io_dout[7:0];
      sh2 <= sh1; sh1 <= sh0; sh0 <= src;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    chk("sel", {31'd0, irq_sel}, {31'd0, io_addr[13]});
    chk("req", {31'd0, interrupt_request}, {31'd0, m_req});
    if (io_addr[13]) begin
      case (io_addr[3:2])
        2'd0:    e = {24'd0, m_pend};
        2'd1:    e = {24'd0, m_en};
        2'd2:    e = lowest(m_pend & m_en);
        default: e = {24'd0, m_mode};
      endcase
      chk("din", irq_din, e);
    end
  end

  function automatic logic [31:0] ra(input int off);
    return 32'h2000 | (off << 2);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk); io_rd = 1'b0; io_wr = 1'b0;
    end
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    @(negedge clk); io_addr = ra(off); io_dout = data; io_wr = 1'b1; io_rd = 1'b0;
    @(negedge clk); io_wr = 1'b0;
  endtask

  task automatic claim_rd();
    @(negedge clk); io_addr = ra(2); io_rd = 1'b1; io_wr = 1'b0;
    @(negedge clk); io_rd = 1'b0;
  endtask

  task automatic peek(input int off, input logic [31:0] exp, input string name);
    @(negedge clk); io_addr = ra(off); io_rd = 1'b0; io_wr = 1'b0;
    #3 chk(name, irq_din, exp);
  endtask

  initial begin
    int cnt;
    bit got;
    cyc(3);
    @(negedge clk); resetq = 1'b1;

    // Random traffic, with one reset pulse in the middle
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      resetq  = (n != 700);
      io_rd   = ($urandom_range(0, 5) == 0);
      io_wr   = ($urandom_range(0, 4) == 0);
      io_addr = {18'd0, 1'($urandom_range(0, 3) != 0), 9'd0, 2'($urandom), 2'd0};
      io_dout = $urandom;
      if ($urandom_range(0, 2) == 0) src = 8'($urandom);
    end

    // Reset mid-run
    @(negedge clk); src = '0; io_rd = 1'b0; io_wr = 1'b0;
    #1 resetq = 1'b0;
    cyc(2);
    @(negedge clk); resetq = 1'b1;
    peek(0, 32'h0, "rst_pending");
    peek(1, 32'h0, "rst_enable");
    peek(3, 32'hFF, "rst_mode");
    peek(2, NONE, "rst_claim");
    chk("rst_req", {31'd0, interrupt_request}, 32'd0);

    // Single pulse latency and claim
    wr(1, 32'h04);
    @(negedge clk); src[2] = 1'b1;
    cnt = 0; got = 0;
    while (!got && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) src[2] = 1'b0;
      if (interrupt_request) got = 1;
    end
    chk("irq_latency", cnt, LAT);
    peek(0, 32'h04, "pend_after_pulse");
    peek(2, 32'h2, "claim_src2");
    @(negedge clk); io_addr = ra(2); io_rd = 1'b1;
    #3 chk("claim_rd_val", irq_din, 32'h2);
    @(negedge clk); io_rd = 1'b0; io_addr = ra(0);
    #3 chk("pend_after_claim", irq_din, 32'h0);
    chk("req_hold", {31'd0, interrupt_request}, 32'd1);
    @(negedge clk);
    #3 chk("req_drop", {31'd0, interrupt_request}, 32'd0);

    // Priority
    wr(1, 32'hFF);
    @(negedge clk); src = 8'h22;
    @(negedge clk); src = 8'h00;
    cyc(LAT + 1);
    peek(2, 32'h1, "claim_first");
    claim_rd();
    peek(2, 32'h5, "claim_second");
    claim_rd();
    peek(2, NONE, "claim_none");

    // Level mode
    wr(3, 32'hF7);
    @(negedge clk); src[3] = 1'b1;
    cyc(LAT + 1);
    wr(0, 32'h08);
    peek(0, 32'h08, "level_reset");
    @(negedge clk); src[3] = 1'b0;
    cyc(D + 2);
    wr(0, 32'h08);
    peek(0, 32'h0, "level_cleared");

    // Set wins over W1C, then masking
    @(negedge clk); src[0] = 1'b1;
    @(negedge clk); src[0] = 1'b0;
    cyc(LAT + 1);
    peek(0, 32'h01, "edge0_pend");
    wr(0, 32'h01);
    peek(0, 32'h0, "edge0_cleared");
    @(negedge clk); src[0] = 1'b1;
    repeat (D) @(negedge clk);
    io_addr = ra(0); io_dout = 32'h01; io_wr = 1'b1; src[0] = 1'b0;
    @(negedge clk); io_wr = 1'b0;
    peek(0, 32'h01, "set_wins");
    wr(1, 32'h00);
    cyc(2);
    #3 chk("req_masked", {31'd0, interrupt_request}, 32'd0);
    peek(0, 32'h01, "pend_masked");

    // Write outside the block's address window
    @(negedge clk); io_addr = 32'h0004; io_dout = 32'hFF; io_wr = 1'b1;
    #3 chk("unsel_sel", {31'd0, irq_sel}, 32'd0);
    @(negedge clk); io_wr = 1'b0;
    peek(1, 32'h00, "unsel_enable");
    peek(0, 32'h01, "unsel_pending");
    peek(3, 32'hF7, "unsel_mode");

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/j1_irq_ctrl.md
Name: j1_irq_ctrl

Overview:
Interrupt controller feeding the j1 core's single `interrupt_request` input. It collects NSRC external sources, synchronises them and latches them as pending bits. Mask, edge/level mode, pending and claim registers are exposed on the j1 IO bus (io_rd/io_wr/io_addr/io_dout). The core's IO read mux selects `irq_din` whenever `irq_sel` is high.

Parameters:
- NSRC, 8: number of interrupt sources, 1..31.
- SEL_BIT, 13: io_addr bit that selects this block (base 0x2000).

Ports:
- clk  in  1  system clock.
- resetq  in  1  reset; asynchronous, active-low.
- io_rd  in  1  j1 IO read strobe, one cycle.
- io_wr  in  1  j1 IO write strobe, one cycle.
- io_addr  in  32  j1 IO address (st0).
- io_dout  in  32  j1 IO write data (st1).
- src  in  NSRC  raw interrupt sources, asynchronous to clk.
- irq_sel  out  1  combinational: io_addr[SEL_BIT].
- irq_din  out  32  combinational read data for the addressed register.
- interrupt_request  out  1  registered OR of (pending & enable).

Behaviour:
- Register map, selected by irq_sel, offset io_addr[3:2]:
  - 0 PENDING: read. Writing 1 clears that bit (W1C).
  - 1 ENABLE: read/write mask.
  - 2 CLAIM: read only. Returns the index of the lowest-numbered pending&enabled source, or 0x80000000 if none.
  - 3 MODE: read/write. 1 = rising-edge, 0 = level.
  - Unused upper bits read 0. Bits above NSRC are ignored on write.
- Reads are combinational: irq_din is valid in the same cycle as io_addr, because j1 samples io_din that cycle. Side effects of a read take effect at the next clk edge.
- Reset values: pending=0, enable=0, mode=all 1 (edge), sync/sample flops=0, interrupt_request=0. irq_din follows the reset state.
- Source path, per bit:
  - Synchroniser or single sample register (see Optional Feature) produces s.
  - Previous-value register produces p.
  - edge = s & ~p; set = mode ? edge : s.
  - pending_next = set | (pending & ~clr).
  - clr = W1C bit, or the CLAIM read of that index (io_rd & sel & offset 2).
  - Set wins over clear in the same cycle.
- Level mode: a pending bit cannot be cleared while the source stays high. It re-sets the cycle after a clear.
- interrupt_request is registered: high the cycle after pending&enable becomes nonzero. It drops the cycle after the last enabled pending bit clears or is masked.
- A CLAIM read with nothing pending has no side effect.
- ENABLE write and an edge in the same cycle: the pending bit still sets; the mask only gates the request.
- Latency from the first clk edge that samples src high to interrupt_request high:
  - 4 edges with J1_IRQ_SYNC_EN.
  - 3 edges without it.
- Minimum recognised edge-mode pulse: 1 clk (synchronous source) or 2 clk (asynchronous source).
- Reset asserted mid-operation clears all state immediately. Pending edges are lost.
- io_rd/io_wr while irq_sel=0: no effect.
- Simultaneous io_rd and io_wr cannot occur on the j1; if they do, both actions apply.

Optional Feature:
- Macro J1_IRQ_SYNC_EN.
- Defined: each src bit passes through a 2-flop synchroniser before the edge detector. Asynchronous sources are safe.
- Undefined: a single sample flop. Only legal for clk-synchronous sources; saves NSRC flops and one cycle of latency.

Decomposition:
- Package j1_irq_pkg:
  - register offset constants (OFF_PENDING=0, OFF_ENABLE=1, OFF_CLAIM=2, OFF_MODE=3);
  - CLAIM_NONE=32'h80000000;
  - default NSRC.
- Sub-module j1_irq_src: one per source via generate. Contains the synchroniser/sample flop, previous-value flop and edge/level select, and outputs `set`.
- Top level holds the registers, priority encoder, IO decode and request flop.

Test Plan:
1. Reset: resetq low mid-run, then high → PENDING=0, ENABLE=0, MODE=0xFF, CLAIM=0x80000000, interrupt_request=0.
2. ENABLE=0x04; pulse src[2] for 1 clk → PENDING=0x04; interrupt_request rises on the 4th edge (3rd without macro).
   - CLAIM read → 0x2; next cycle PENDING=0, interrupt_request falls one cycle later.
3. ENABLE=0xFF; pulse src[5] and src[1] together → CLAIM=1.
   - After the claim, CLAIM=5; after the second claim, CLAIM=0x80000000.
4. MODE=0xF7; hold src[3] high; write PENDING=0x08 → bit 3 reads 1 again next cycle.
   - Drop src[3], W1C again → PENDING=0.
5. Same-cycle W1C of bit 0 with a new edge on src[0] → bit 0 stays pending.
   - ENABLE=0 with pending nonzero → interrupt_request=0 and PENDING unchanged.
6. io_wr with io_addr=0x0004 (SEL_BIT low) → no register changes; irq_sel=0.
